// File: rtl/vga_sync_gen_if.sv
// Bundle of the timing outputs and the pixel-advance enable shared between
// the VGA timing generator (master) and its consumer (slave).
interface vga_sync_gen_if #(
    parameter int CNT_W = 10
);
    logic             i_enable;
    logic             o_hsync;
    logic             o_vsync;
    logic [CNT_W-1:0] o_col_counter;
    logic [CNT_W-1:0] o_row_counter;
    logic             o_active;
    logic             o_line_start;
    logic             o_frame_start;

    modport master (
        input  i_enable,
        output o_hsync,
        output o_vsync,
        output o_col_counter,
        output o_row_counter,
        output o_active,
        output o_line_start,
        output o_frame_start
    );

    modport slave (
        output i_enable,
        input  o_hsync,
        input  o_vsync,
        input  o_col_counter,
        input  o_row_counter,
        input  o_active,
        input  o_line_start,
        input  o_frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing source. One clk per pixel. Every output is a flop
// computed from the next (col,row), so all outputs describe the position
// shown on the counters in the same cycle with no skew.
module vga_sync_gen #(
    parameter int TOTAL_COLS      = 800,
    parameter int TOTAL_ROWS      = 525,
    parameter int ACTIVE_COLS     = 640,
    parameter int ACTIVE_ROWS     = 480,
    parameter int H_FRONT_PORCH   = 16,
    parameter int H_SYNC_WIDTH    = 96,
    parameter int V_FRONT_PORCH   = 10,
    parameter int V_SYNC_WIDTH    = 2,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int CNT_W           = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    vga_sync_gen_if.master  vif
);
    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(TOTAL_ROWS - 1);
    localparam logic [CNT_W-1:0] COL_ACT   = CNT_W'(ACTIVE_COLS);
    localparam logic [CNT_W-1:0] ROW_ACT   = CNT_W'(ACTIVE_ROWS);
    localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
    localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);
    // Level driven on a sync line while the pulse is asserted.
    localparam logic             SYNC_ON   = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic             SYNC_OFF  = ~SYNC_ON;

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic [CNT_W-1:0] col_nxt;
    logic [CNT_W-1:0] row_nxt;
    logic             col_wrap;

    // Next position and the outputs that will describe it; stall holds
    // everything except the strobes, which drop so they never repeat.
    always_comb begin
        col_wrap = (col_q == COL_LAST);
        col_nxt  = col_wrap ? '0 : col_q + 1'b1;
        if (col_wrap) begin
            row_nxt = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
            row_nxt = row_q;
        end

        col_d         = col_q;
        row_d         = row_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (vif.i_enable) begin
            col_d         = col_nxt;
            row_d         = row_nxt;
            hsync_d       = ((col_nxt >= HS_FIRST) && (col_nxt <= HS_LAST)) ? SYNC_ON : SYNC_OFF;
            vsync_d       = ((row_nxt >= VS_FIRST) && (row_nxt <= VS_LAST)) ? SYNC_ON : SYNC_OFF;
            active_d      = (col_nxt < COL_ACT) && (row_nxt < ROW_ACT);
            line_start_d  = col_wrap;
            frame_start_d = col_wrap && (row_q == ROW_LAST);
        end
    end

    // Reset parks the counters on the last pixel so the first enabled edge
    // lands on (0,0) with both strobes raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q         <= COL_LAST;
            row_q         <= ROW_LAST;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.o_col_counter = col_q;
    assign vif.o_row_counter = row_q;
    assign vif.o_hsync       = hsync_q;
    assign vif.o_vsync       = vsync_q;
    assign vif.o_active      = active_q;
    assign vif.o_line_start  = line_start_q;
    assign vif.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance (a), the same timing with
// active-high sync (b), and a tiny 20x15 timing (c) so full frames fit in a
// short run. All share clk, rst_n and the enable.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst_n;
    logic en;

    always #5 clk = ~clk;

    vga_sync_gen_if #(.CNT_W(10)) ifa ();
    vga_sync_gen_if #(.CNT_W(10)) ifb ();
    vga_sync_gen_if #(.CNT_W(5))  ifc ();

    assign ifa.i_enable = en;
    assign ifb.i_enable = en;
    assign ifc.i_enable = en;

    vga_sync_gen #(.SYNC_ACTIVE_LOW(1)) dut_a (.clk(clk), .rst_n(rst_n), .vif(ifa));
    vga_sync_gen #(.SYNC_ACTIVE_LOW(0)) dut_b (.clk(clk), .rst_n(rst_n), .vif(ifb));
    // hsync cols 14..16, vsync rows 11..12, frame = 300 cycles
    vga_sync_gen #(
        .TOTAL_COLS(20), .TOTAL_ROWS(15), .ACTIVE_COLS(12), .ACTIVE_ROWS(10),
        .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2),
        .SYNC_ACTIVE_LOW(1), .CNT_W(5)
    ) dut_c (.clk(clk), .rst_n(rst_n), .vif(ifc));

    int n_cmp = 0;
    int n_bad = 0;

    // {col,row,hsync,vsync,active,line_start,frame_start} of instance a
    function automatic logic [24:0] snap_a();
        return {ifa.o_col_counter, ifa.o_row_counter, ifa.o_hsync, ifa.o_vsync,
                ifa.o_active, ifa.o_line_start, ifa.o_frame_start};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (snap_a() !== {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_a: got %h required %h", snap_a(),
                     {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        n_cmp++;
        if ({ifb.o_hsync, ifb.o_vsync} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_b_sync_level: got %b required 00", {ifb.o_hsync, ifb.o_vsync});
        end
        n_cmp++;
        if ({ifc.o_col_counter, ifc.o_row_counter} !== {5'd19, 5'd14}) begin
            n_bad++;
            $display("FAIL reset_c_pos: got col %0d row %0d required 19 14",
                     ifc.o_col_counter, ifc.o_row_counter);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (snap_a() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL first_edge_a: got %h required %h", snap_a(),
                     {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        end
        n_cmp++;
        if ({ifc.o_col_counter, ifc.o_row_counter, ifc.o_frame_start} !== {5'd0, 5'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL first_edge_c: got col %0d row %0d fs %b required 0 0 1",
                     ifc.o_col_counter, ifc.o_row_counter, ifc.o_frame_start);
        end
        @(negedge clk);
        n_cmp++;
        if (snap_a() !== {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL second_edge_a: got %h required %h", snap_a(),
                     {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        end
    endtask

    // Walk col 2..799 of row 0 on instances a and b, then the wrap to row 1.
    task automatic test_horizontal();
        logic exp_hs_on;
        int   bad_here;
        bad_here = 0;
        for (int c = 2; c < 800; c++) begin
            @(negedge clk);
            exp_hs_on = (c >= 656) && (c <= 751);
            n_cmp++;
            if ({ifa.o_col_counter, ifa.o_row_counter, ifa.o_active, ifa.o_hsync,
                 ifb.o_hsync, ifa.o_line_start} !==
                {10'(c), 10'd0, (c < 640), ~exp_hs_on, exp_hs_on, 1'b0}) begin
                n_bad++;
                bad_here++;
                if (bad_here < 10)
                    $display("FAIL hline c=%0d: got col %0d row %0d act %b hs_a %b hs_b %b ls %b required act %b hs_a %b hs_b %b",
                             c, ifa.o_col_counter, ifa.o_row_counter, ifa.o_active,
                             ifa.o_hsync, ifb.o_hsync, ifa.o_line_start,
                             (c < 640), ~exp_hs_on, exp_hs_on);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (snap_a() !== {10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL line_wrap_a: got %h required %h", snap_a(),
                     {10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
        end
    endtask

    // Starts at (0,1): stall at col 655, then stall on a line start.
    task automatic test_stall();
        repeat (655) @(negedge clk);
        n_cmp++;
        if ({ifa.o_col_counter, ifa.o_hsync} !== {10'd655, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_pre: got col %0d hs %b required 655 1", ifa.o_col_counter, ifa.o_hsync);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ifa.o_col_counter, ifa.o_row_counter, ifa.o_hsync, ifb.o_hsync, ifa.o_active} !==
                {10'd655, 10'd1, 1'b1, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL stall_hold i=%0d: got col %0d row %0d hs_a %b hs_b %b act %b required 655 1 1 0 0",
                         i, ifa.o_col_counter, ifa.o_row_counter, ifa.o_hsync, ifb.o_hsync, ifa.o_active);
            end
        end
        en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ifa.o_col_counter, ifa.o_hsync, ifb.o_hsync} !== {10'd656, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_resume: got col %0d hs_a %b hs_b %b required 656 0 1",
                     ifa.o_col_counter, ifa.o_hsync, ifb.o_hsync);
        end
        repeat (144) @(negedge clk);
        n_cmp++;
        if ({ifa.o_col_counter, ifa.o_row_counter, ifa.o_line_start} !== {10'd0, 10'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_ls_pre: got col %0d row %0d ls %b required 0 2 1",
                     ifa.o_col_counter, ifa.o_row_counter, ifa.o_line_start);
        end
        en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ifa.o_col_counter, ifa.o_line_start, ifa.o_frame_start} !== {10'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL stall_ls_clear: got col %0d ls %b fs %b required 0 0 0",
                     ifa.o_col_counter, ifa.o_line_start, ifa.o_frame_start);
        end
        en = 1'b1;
    endtask

    // Full frame on the small instance, from one frame_start to the next.
    task automatic test_vertical();
        int found;
        int bad_here;
        int ec;
        int er;
        logic [10:0] exp_v;
        logic [10:0] got_v;
        found = 0;
        bad_here = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (ifc.o_frame_start === 1'b1) found = 1;
        end
        n_cmp++;
        if (found == 0) begin
            n_bad++;
            $display("FAIL vert_sync_timeout: got no frame_start in 400 cycles required one");
        end
        ec = 0;
        er = 0;
        for (int n = 1; n < 300; n++) begin
            @(negedge clk);
            ec++;
            if (ec == 20) begin
                ec = 0;
                er++;
            end
            exp_v = {5'(ec), 5'(er), 1'b0};
            got_v = {ifc.o_col_counter, ifc.o_row_counter, ifc.o_frame_start};
            n_cmp++;
            if (got_v !== exp_v ||
                ifc.o_active !== ((ec < 12) && (er < 10)) ||
                ifc.o_vsync  !== !((er >= 11) && (er <= 12)) ||
                ifc.o_hsync  !== !((ec >= 14) && (ec <= 16)) ||
                ifc.o_line_start !== (ec == 0)) begin
                n_bad++;
                bad_here++;
                if (bad_here < 10)
                    $display("FAIL vframe n=%0d: got col %0d row %0d fs %b act %b vs %b hs %b ls %b required col %0d row %0d",
                             n, ifc.o_col_counter, ifc.o_row_counter, ifc.o_frame_start,
                             ifc.o_active, ifc.o_vsync, ifc.o_hsync, ifc.o_line_start, ec, er);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({ifc.o_col_counter, ifc.o_row_counter, ifc.o_frame_start, ifc.o_line_start} !==
            {5'd0, 5'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL frame_period: got col %0d row %0d fs %b ls %b after 300 cycles required 0 0 1 1",
                     ifc.o_col_counter, ifc.o_row_counter, ifc.o_frame_start, ifc.o_line_start);
        end
    endtask

    task automatic test_async_reset();
        int found;
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (ifc.o_col_counter === 5'd8 && ifc.o_row_counter === 5'd7) found = 1;
        end
        n_cmp++;
        if (found == 0) begin
            n_bad++;
            $display("FAIL arst_reach_timeout: got no (8,7) in 400 cycles required it");
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (snap_a() !== {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL arst_a: got %h required %h", snap_a(),
                     {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        n_cmp++;
        if ({ifc.o_col_counter, ifc.o_row_counter, ifc.o_active, ifc.o_hsync, ifc.o_vsync} !==
            {5'd19, 5'd14, 1'b0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL arst_c: got col %0d row %0d act %b hs %b vs %b required 19 14 0 1 1",
                     ifc.o_col_counter, ifc.o_row_counter, ifc.o_active, ifc.o_hsync, ifc.o_vsync);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (snap_a() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL arst_first_edge: got %h required %h", snap_a(),
                     {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        end
        @(negedge clk);
        n_cmp++;
        if ({ifa.o_col_counter, ifa.o_line_start, ifa.o_frame_start} !== {10'd1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL arst_second_edge: got col %0d ls %b fs %b required 1 0 0",
                     ifa.o_col_counter, ifa.o_line_start, ifa.o_frame_start);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        test_reset();
        test_horizontal();
        test_stall();
        test_vertical();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
